// File: rtl/gift_manager.sv
// Multi-slot power-up engine: spawns random gifts at broken bricks, drops them
// once per frame, and reports paddle catches to the game FSM one per cycle.
module gift_manager #(
  parameter int          N_SLOTS      = 4,
  parameter int          X_W          = 10,
  parameter int          SCREEN_H     = 480,
  parameter int          GIFT_W       = 16,
  parameter int          GIFT_H       = 8,
  parameter int          PD_W         = 64,
  parameter int          PD_H         = 10,
  parameter int          FALL_STEP    = 2,
  parameter int          SPAWN_THRESH = 8,
  parameter logic [15:0] SEED         = 16'hACE1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   brick_hit,
  input  logic [X_W-1:0]         hit_x,
  input  logic [X_W-1:0]         hit_y,
  input  logic                   lost,
  input  logic [X_W-1:0]         paddle_x,
  input  logic [X_W-1:0]         paddle_y,
  output logic [N_SLOTS-1:0]     slot_active,
  output logic [3*N_SLOTS-1:0]   slot_kind,
  output logic [X_W*N_SLOTS-1:0] slot_x,
  output logic [X_W*N_SLOTS-1:0] slot_y,
  output logic                   catch_valid,
  output logic [2:0]             catch_kind
);

  typedef enum logic [1:0] {
    S_FREE   = 2'd0,
    S_FALL   = 2'd1,
    S_CAUGHT = 2'd2
  } slot_state_e;

  // Geometry is evaluated one bit wider than the coordinates so sums never wrap.
  localparam int            CW         = X_W + 1;
  localparam logic [CW-1:0] C_GIFT_W   = CW'(GIFT_W);
  localparam logic [CW-1:0] C_GIFT_H   = CW'(GIFT_H);
  localparam logic [CW-1:0] C_PD_W     = CW'(PD_W);
  localparam logic [CW-1:0] C_PD_H     = CW'(PD_H);
  localparam logic [CW-1:0] C_STEP     = CW'(FALL_STEP);
  localparam logic [CW-1:0] C_SCREEN_H = CW'(SCREEN_H);
  localparam logic [5:0]    C_THRESH   = 6'(SPAWN_THRESH);
  localparam logic [15:0]   LFSR_TAPS  = 16'hB400;

  slot_state_e    r_state [N_SLOTS];
  slot_state_e    w_state_n [N_SLOTS];
  logic [2:0]     r_kind [N_SLOTS];
  logic [2:0]     w_kind_n [N_SLOTS];
  logic [X_W-1:0] r_x [N_SLOTS];
  logic [X_W-1:0] w_x_n [N_SLOTS];
  logic [X_W-1:0] r_y [N_SLOTS];
  logic [X_W-1:0] w_y_n [N_SLOTS];

  logic [15:0]    r_lfsr;
  logic [15:0]    w_lfsr_n;
  logic           r_catch_valid;
  logic           w_catch_valid_n;
  logic [2:0]     r_catch_kind;
  logic [2:0]     w_catch_kind_n;

  logic                 w_spawn_req;
  logic [N_SLOTS-1:0]   w_spawn_gnt;
  logic [N_SLOTS-1:0]   w_report_gnt;
  logic [CW-1:0]        w_y_step [N_SLOTS];
  logic [N_SLOTS-1:0]   w_hit_paddle;
  logic [N_SLOTS-1:0]   w_hit_floor;

  // Right-shifting Galois LFSR; a nonzero seed keeps it off the all-zero state.
  always_comb begin
    w_lfsr_n = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);
  end

  always_comb begin
    for (int i = 0; i < N_SLOTS; i++) begin
      w_y_step[i]     = {1'b0, r_y[i]} + C_STEP;
      w_hit_paddle[i] = ({1'b0, r_x[i]} < ({1'b0, paddle_x} + C_PD_W)) &&
                        (({1'b0, r_x[i]} + C_GIFT_W) > {1'b0, paddle_x}) &&
                        (w_y_step[i] < ({1'b0, paddle_y} + C_PD_H)) &&
                        ((w_y_step[i] + C_GIFT_H) > {1'b0, paddle_y});
      w_hit_floor[i]  = (w_y_step[i] + C_GIFT_H) >= C_SCREEN_H;
    end
  end

  // One-hot grants: lowest FREE slot takes a spawn, lowest CAUGHT slot reports.
  always_comb begin
    logic spawn_taken;
    logic report_taken;
    w_spawn_req  = brick_hit && !lost && ({1'b0, r_lfsr[4:0]} < C_THRESH);
    w_spawn_gnt  = '0;
    w_report_gnt = '0;
    spawn_taken  = 1'b0;
    report_taken = 1'b0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!spawn_taken && r_state[i] == S_FREE) begin
        w_spawn_gnt[i] = w_spawn_req;
        spawn_taken    = 1'b1;
      end
      if (!report_taken && r_state[i] == S_CAUGHT) begin
        w_report_gnt[i] = 1'b1;
        report_taken    = 1'b1;
      end
    end
  end

  // NOTE: every output of this block is given a default before any branch, so no latches are inferred.
  always_comb begin
    w_catch_valid_n = 1'b0;
    w_catch_kind_n  = r_catch_kind;
    for (int i = 0; i < N_SLOTS; i++) begin
      w_state_n[i] = r_state[i];
      w_kind_n[i]  = r_kind[i];
      w_x_n[i]     = r_x[i];
      w_y_n[i]     = r_y[i];
      if (lost) begin
        w_state_n[i] = S_FREE;
      end else begin
        case (r_state[i])
          S_FREE: begin
            if (w_spawn_gnt[i]) begin
              w_state_n[i] = S_FALL;
              w_kind_n[i]  = r_lfsr[7:5];
              w_x_n[i]     = hit_x;
              w_y_n[i]     = hit_y;
            end
          end
          S_FALL: begin
            if (frame_tick) begin
              if (w_hit_paddle[i]) begin
                w_state_n[i] = S_CAUGHT;
                w_y_n[i]     = w_y_step[i][X_W-1:0];
              end else if (w_hit_floor[i]) begin
                w_state_n[i] = S_FREE;
              end else begin
                w_y_n[i]     = w_y_step[i][X_W-1:0];
              end
            end
          end
          S_CAUGHT: begin
            if (w_report_gnt[i]) begin
              w_state_n[i]    = S_FREE;
              w_catch_valid_n = 1'b1;
              w_catch_kind_n  = r_kind[i];
            end
          end
          default: w_state_n[i] = S_FREE;
        endcase
      end
    end
  end

  // NOTE: the per-slot arrays are a handful of flops, not a RAM, so they take the reset like any register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lfsr        <= SEED;
      r_catch_valid <= 1'b0;
      r_catch_kind  <= 3'd0;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_state[i] <= S_FREE;
        r_kind[i]  <= 3'd0;
        r_x[i]     <= '0;
        r_y[i]     <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_lfsr        <= w_lfsr_n;
      r_catch_valid <= w_catch_valid_n;
      r_catch_kind  <= w_catch_kind_n;
      for (int i = 0; i < N_SLOTS; i++) begin
        r_state[i] <= w_state_n[i];
        r_kind[i]  <= w_kind_n[i];
        r_x[i]     <= w_x_n[i];
        r_y[i]     <= w_y_n[i];
      end
    end
  end

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
    assign slot_active[g]          = (r_state[g] == S_FALL);
    assign slot_kind[3*g +: 3]     = r_kind[g];
    assign slot_x[X_W*g +: X_W]    = r_x[g];
    assign slot_y[X_W*g +: X_W]    = r_y[g];
  end

  assign catch_valid = r_catch_valid;
  assign catch_kind  = r_catch_kind;

endmodule

// File: tb/tb_gift_manager.sv
// Directed self-checking bench for gift_manager: spawn, fall, catch, floor miss,
// slot exhaustion, report ordering, lost and mid-run reset.
module tb_gift_manager;

  localparam logic [15:0] TB_SEED = 16'hACE3;  // lfsr[4:0]=3, lfsr[7:5]=7

  logic        clock = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        brick_hit;
  logic [9:0]  hit_x;
  logic [9:0]  hit_y;
  logic        lost;
  logic [9:0]  paddle_x;
  logic [9:0]  paddle_y;
  logic [3:0]  slot_active;
  logic [11:0] slot_kind;
  logic [39:0] slot_x;
  logic [39:0] slot_y;
  logic        catch_valid;
  logic [2:0]  catch_kind;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] m_lfsr;
  logic [2:0]  k;
  logic [2:0]  ks [4];

  gift_manager #(.SEED(TB_SEED)) dut (
    .clock       (clock),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .brick_hit   (brick_hit),
    .hit_x       (hit_x),
    .hit_y       (hit_y),
    .lost        (lost),
    .paddle_x    (paddle_x),
    .paddle_y    (paddle_y),
    .slot_active (slot_active),
    .slot_kind   (slot_kind),
    .slot_x      (slot_x),
    .slot_y      (slot_y),
    .catch_valid (catch_valid),
    .catch_kind  (catch_kind)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference LFSR: the value visible at posedge+1 is the one the next edge uses.
  always @(posedge clock) m_lfsr <= reset ? TB_SEED : lfsr_step(m_lfsr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Step until the reference LFSR gives the wanted low bits for the next edge.
  task automatic wait_rnd(input bit want_spawn, input int exact, input string tag);
    int n = 0;
    while (n < 3000 && !(exact >= 0 ? (int'(m_lfsr[4:0]) == exact)
                                    : ((m_lfsr[4:0] < 5'd8) == want_spawn))) begin
      step();
      n++;
    end
    check({tag, " lfsr wait bound"}, 64'(n < 3000), 64'd1);
  endtask

  task automatic spawn(input logic [9:0] x, input logic [9:0] y, output logic [2:0] kind);
    wait_rnd(1'b1, -1, "spawn");
    kind      = m_lfsr[7:5];
    hit_x     = x;
    hit_y     = y;
    brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; frame_tick = 1'b0; brick_hit = 1'b0; lost = 1'b0;
    hit_x = '0; hit_y = '0; paddle_x = 10'd600; paddle_y = 10'd20;
    repeat (3) step();

    check("reset active", slot_active, 0);
    check("reset kind",   slot_kind,   0);
    check("reset x",      slot_x,      0);
    check("reset y",      slot_y,      0);
    check("reset cvalid", catch_valid, 0);
    check("reset ckind",  catch_kind,  0);

    // First edge after reset sees lfsr = SEED: low bits 3 spawn, kind 7.
    reset = 1'b0; hit_x = 10'd100; hit_y = 10'd40; brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    check("t1 active", slot_active,  4'b0001);
    check("t1 x0",     slot_x[9:0],  100);
    check("t1 y0",     slot_y[9:0],  40);
    check("t1 kind0",  slot_kind[2:0], 7);
    tick();
    check("t1 fall y0", slot_y[9:0], 42);

    // Non-qualifying random value: no spawn.
    wait_rnd(1'b0, 20, "t2");
    hit_x = 10'd200; hit_y = 10'd200; brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    check("t2 active", slot_active, 4'b0001);
    check("t2 x1",     slot_x[19:10], 0);
    lost = 1'b1;
    step();
    lost = 1'b0;
    check("t2 lost clears", slot_active, 0);

    // Catch: touching edge (402+8 == 410) is not a catch, next step is.
    spawn(10'd100, 10'd400, k);
    paddle_x = 10'd90; paddle_y = 10'd410;
    check("t3 spawned y0", slot_y[9:0], 400);
    tick();
    check("t3 edge y0",     slot_y[9:0], 402);
    check("t3 edge active", slot_active, 4'b0001);
    tick();
    check("t3 caught active", slot_active, 0);
    check("t3 caught cvalid", catch_valid, 0);
    check("t3 caught y0",     slot_y[9:0], 404);
    step();
    check("t3 cvalid", catch_valid, 1);
    check("t3 ckind",  catch_kind,  k);
    step();
    check("t3 cvalid drop", catch_valid, 0);
    check("t3 ckind hold",  catch_kind,  k);
    paddle_x = 10'd600; paddle_y = 10'd20;

    // Floor: spawn with a concurrent tick does not move; 470+8 stays, 472+8 frees.
    wait_rnd(1'b1, -1, "t4");
    hit_x = 10'd300; hit_y = 10'd468; brick_hit = 1'b1; frame_tick = 1'b1;
    step();
    brick_hit = 1'b0; frame_tick = 1'b0;
    check("t4 spawn no move", slot_y[9:0], 468);
    tick();
    check("t4 y 470",      slot_y[9:0], 470);
    check("t4 still live", slot_active, 4'b0001);
    tick();
    check("t4 floor free", slot_active, 0);
    check("t4 cvalid a",   catch_valid, 0);
    step();
    check("t4 cvalid b",   catch_valid, 0);
    step();
    check("t4 cvalid c",   catch_valid, 0);

    // Fill all slots, overflow hit ignored, two simultaneous catches.
    spawn(10'd0,   10'd100, ks[0]);
    spawn(10'd100, 10'd100, ks[1]);
    spawn(10'd140, 10'd100, ks[2]);
    spawn(10'd300, 10'd100, ks[3]);
    check("t5 full", slot_active, 4'b1111);
    wait_rnd(1'b1, -1, "t5 overflow");
    hit_x = 10'd500; hit_y = 10'd500; brick_hit = 1'b1;
    step();
    brick_hit = 1'b0;
    check("t5 overflow active", slot_active, 4'b1111);
    check("t5 overflow xs", slot_x, {10'd300, 10'd140, 10'd100, 10'd0});
    paddle_x = 10'd100; paddle_y = 10'd100;
    tick();
    check("t5 caught active", slot_active, 4'b1001);
    check("t5 cvalid 0",      catch_valid, 0);
    step();
    check("t5 first cvalid", catch_valid, 1);
    check("t5 first ckind",  catch_kind,  ks[1]);
    step();
    check("t5 second cvalid", catch_valid, 1);
    check("t5 second ckind",  catch_kind,  ks[2]);
    step();
    check("t5 done cvalid", catch_valid, 0);
    check("t5 done ckind",  catch_kind,  ks[2]);

    // Two pending catches discarded by lost; then a hit together with lost.
    spawn(10'd100, 10'd100, k);
    spawn(10'd140, 10'd100, k);
    check("t6 refill", slot_active, 4'b1111);
    tick();
    lost = 1'b1;
    check("t6 caught active", slot_active, 4'b1001);
    step();
    lost = 1'b0;
    check("t6 lost active", slot_active, 0);
    check("t6 lost cvalid", catch_valid, 0);
    step();
    check("t6 no late report", catch_valid, 0);
    wait_rnd(1'b1, -1, "t6 hit+lost");
    hit_x = 10'd50; hit_y = 10'd50; brick_hit = 1'b1; lost = 1'b1;
    step();
    brick_hit = 1'b0; lost = 1'b0;
    check("t6 hit+lost active", slot_active, 0);
    step();
    check("t6 hit+lost later", slot_active, 0);

    // Reset in the middle of activity.
    spawn(10'd50, 10'd60, k);
    check("t7 pre-reset active", slot_active, 4'b0001);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t7 active", slot_active, 0);
    check("t7 x",      slot_x,      0);
    check("t7 y",      slot_y,      0);
    check("t7 kind",   slot_kind,   0);
    check("t7 ckind",  catch_kind,  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
